// File: rtl/ihex_mem_arbiter.sv
// ihex_mem_arbiter: shares a byte RAM between the HEX loader and the CPU and sequences the boot.
// Optional CPU write protection of the low region is enabled with IHEX_ARB_WRITE_PROTECT_EN.
module ihex_mem_arbiter #(
  parameter int          ADDR_WIDTH   = 12,
  parameter logic [31:0] BASE_ADDRESS = 32'h0
`ifdef IHEX_ARB_WRITE_PROTECT_EN
  , parameter logic [ADDR_WIDTH-1:0] PROTECT_LIMIT = 12'h100
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dec_we,
  input  logic [7:0]            dec_data,
  input  logic [31:0]           dec_address,
  output logic                  dec_write_done,
  input  logic                  end_of_file,
  input  logic                  line_error,
  input  logic [31:0]           start_address,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [7:0]            cpu_wdata,
  output logic [7:0]            cpu_rdata,
  output logic                  cpu_ack,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  cpu_hold,
  output logic [31:0]           boot_address,
  output logic                  fault,
  output logic [7:0]            error_count
);
  typedef enum logic [1:0] {LOAD, RUN, FAULT} state_t;
  localparam logic [32:0] LO = {1'b0, BASE_ADDRESS};
  localparam logic [32:0] HI = LO + (33'd1 << ADDR_WIDTH);
  state_t state_q, state_d;
  logic [31:0] boot_address_q, boot_address_d;
  logic [7:0] error_count_q, error_count_d;
  logic cpu_ack_q, cpu_ack_d, cpu_hold_q, cpu_hold_d, fault_q, fault_d;
  logic in_range, clear, cpu_grant, cpu_drop;
  logic [8:0] err_sum;
  always_comb begin
    in_range = ({1'b0, dec_address} >= LO) && ({1'b0, dec_address} < HI);
    clear = dec_we && state_q != LOAD;
    // Errors of this cycle are folded in before the EOF decision
    err_sum = (clear ? 9'd0 : {1'b0, error_count_q}) + {8'd0, line_error} + {8'd0, dec_we && !in_range};
    error_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    state_d = clear ? LOAD
            : (state_q == LOAD && end_of_file) ? (error_count_d == 8'd0 ? RUN : FAULT)
            : state_q;
    boot_address_d = (state_q == LOAD && state_d == RUN) ? start_address : boot_address_q;
    cpu_hold_d = state_d != RUN;
    fault_d = state_d == FAULT;
    cpu_grant = state_q == RUN && !dec_we && cpu_req && !cpu_ack_q;
    cpu_ack_d = cpu_grant;
`ifdef IHEX_ARB_WRITE_PROTECT_EN
    cpu_drop = cpu_we && cpu_address < PROTECT_LIMIT;
`else
    cpu_drop = 1'b0;
`endif
    dec_write_done = dec_we && !reset;
    mem_en = !reset && (dec_we ? in_range : cpu_grant && !cpu_drop);
    mem_we = !reset && (dec_we ? in_range : cpu_grant && cpu_we && !cpu_drop);
    mem_address = dec_we ? dec_address[ADDR_WIDTH-1:0] - BASE_ADDRESS[ADDR_WIDTH-1:0] : cpu_address;
    mem_wdata = dec_we ? dec_data : cpu_wdata;
    cpu_rdata = cpu_ack_q ? mem_rdata : 8'h00;
    cpu_ack = cpu_ack_q;
    cpu_hold = cpu_hold_q;
    fault = fault_q;
    boot_address = boot_address_q;
    error_count = error_count_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= LOAD;
      boot_address_q <= 32'h0;
      error_count_q <= 8'h0;
      cpu_ack_q <= 1'b0;
      cpu_hold_q <= 1'b1;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      boot_address_q <= boot_address_d;
      error_count_q <= error_count_d;
      cpu_ack_q <= cpu_ack_d;
      cpu_hold_q <= cpu_hold_d;
      fault_q <= fault_d;
    end
  end
endmodule

// File: tb/tb_ihex_mem_arbiter.sv
// tb_ihex_mem_arbiter: scoreboard bench for ihex_mem_arbiter with a behavioural sync RAM.
module tb_ihex_mem_arbiter;
  logic clock = 1'b0;
  logic reset, dec_we, end_of_file, line_error, cpu_req, cpu_we;
  logic [7:0] dec_data, cpu_wdata, mem_rdata, mem_wdata, cpu_rdata, error_count;
  logic [31:0] dec_address, start_address, boot_address;
  logic [11:0] cpu_address, mem_address;
  logic dec_write_done, cpu_ack, mem_en, mem_we, cpu_hold, fault;
  logic [7:0] ram [0:4095];
  logic [7:0] exp_q [$];
  int checks = 0;
  int fails = 0;

  always #5 clock = ~clock;

  always @(posedge clock)
    if (mem_en) begin
      if (mem_we) ram[mem_address] <= mem_wdata;
      else mem_rdata <= ram[mem_address];
    end

  ihex_mem_arbiter dut (
    .clock(clock), .reset(reset), .dec_we(dec_we), .dec_data(dec_data),
    .dec_address(dec_address), .dec_write_done(dec_write_done),
    .end_of_file(end_of_file), .line_error(line_error), .start_address(start_address),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .mem_en(mem_en), .mem_we(mem_we),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_hold(cpu_hold), .boot_address(boot_address), .fault(fault), .error_count(error_count)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic dec_write(input logic [31:0] a, input logic [7:0] d, input logic exp_en);
    dec_we = 1'b1; dec_address = a; dec_data = d;
    #1;
    checks++;
    if (dec_write_done !== 1'b1 || mem_en !== exp_en) begin
      fails++;
      $display("FAIL dec_write addr=%h: done=%b mem_en=%b required done=1 mem_en=%b", a, dec_write_done, mem_en, exp_en);
    end
    if (exp_en) begin
      checks++;
      if (mem_we !== 1'b1 || mem_address !== a[11:0] || mem_wdata !== d) begin
        fails++;
        $display("FAIL dec_mem addr=%h: we=%b maddr=%h wdata=%h required we=1 maddr=%h wdata=%h", a, mem_we, mem_address, mem_wdata, a[11:0], d);
      end
    end
    tick;
    dec_we = 1'b0;
  endtask

  task automatic eof(input logic [31:0] s, input logic exp_fault, input logic [31:0] exp_boot);
    end_of_file = 1'b1; start_address = s;
    tick;
    end_of_file = 1'b0;
    checks++;
    if (fault !== exp_fault || cpu_hold !== exp_fault || boot_address !== exp_boot) begin
      fails++;
      $display("FAIL eof: fault=%b hold=%b boot=%h required fault=%b hold=%b boot=%h", fault, cpu_hold, boot_address, exp_fault, exp_fault, exp_boot);
    end
  endtask

  task automatic cpu_access(input logic we, input logic [11:0] a, input logic [7:0] wd, input logic [7:0] exp_rd);
    int n;
    logic [7:0] e;
    cpu_req = 1'b1; cpu_we = we; cpu_address = a; cpu_wdata = wd;
    if (!we) exp_q.push_back(exp_rd);
    #1;
    checks++;
    if (cpu_ack !== 1'b0) begin
      fails++;
      $display("FAIL early_ack addr=%h: ack=%b required 0", a, cpu_ack);
    end
    n = 0;
    do begin
      tick;
      n++;
    end while (cpu_ack !== 1'b1 && n < 4);
    checks++;
    if (n != 1 || cpu_ack !== 1'b1) begin
      fails++;
      $display("FAIL ack_latency addr=%h: cycles=%0d ack=%b required cycles=1 ack=1", a, n, cpu_ack);
    end
    if (!we && cpu_ack === 1'b1) begin
      e = exp_q.pop_front();
      checks++;
      if (cpu_rdata !== e) begin
        fails++;
        $display("FAIL cpu_read addr=%h: rdata=%h required %h", a, cpu_rdata, e);
      end
    end
    cpu_req = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    checks++;
    if (cpu_hold !== 1'b1 || fault !== 1'b0 || cpu_ack !== 1'b0 || cpu_rdata !== 8'h0 ||
        boot_address !== 32'h0 || error_count !== 8'h0 || mem_en !== 1'b0 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL reset: hold=%b fault=%b ack=%b rdata=%h boot=%h err=%h en=%b we=%b required 1 0 0 00 0 00 0 0",
               cpu_hold, fault, cpu_ack, cpu_rdata, boot_address, error_count, mem_en, mem_we);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_load;
    logic [7:0] d [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    for (int i = 0; i < 4; i++) dec_write(32'h10 + i, d[i], 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram[16 + i] !== d[i]) begin
        fails++;
        $display("FAIL ram_load idx=%0d: got=%h required %h", i, ram[16 + i], d[i]);
      end
    end
    eof(32'h40, 1'b0, 32'h40);
  endtask

  task automatic test_cpu;
    cpu_access(1'b0, 12'h011, 8'h00, 8'hA1);
    cpu_access(1'b1, 12'h200, 8'h55, 8'h00);
    cpu_access(1'b0, 12'h200, 8'h00, 8'h55);
  endtask

  task automatic test_out_of_range;
    dec_write(32'h1000, 8'h99, 1'b0);
    checks++;
    if (error_count !== 8'd1 || cpu_hold !== 1'b1) begin
      fails++;
      $display("FAIL out_of_range: err=%0d hold=%b required err=1 hold=1", error_count, cpu_hold);
    end
    eof(32'h80, 1'b1, 32'h40);
  endtask

  task automatic test_recover_saturate;
    dec_write(32'h20, 8'h77, 1'b1);
    checks++;
    if (error_count !== 8'd0 || fault !== 1'b0) begin
      fails++;
      $display("FAIL fault_exit: err=%0d fault=%b required err=0 fault=0", error_count, fault);
    end
    eof(32'h44, 1'b0, 32'h44);
    for (int i = 0; i < 300; i++) begin
      line_error = 1'b1;
      tick;
      line_error = 1'b0;
      tick;
    end
    checks++;
    if (error_count !== 8'hFF || cpu_hold !== 1'b0) begin
      fails++;
      $display("FAIL saturate: err=%h hold=%b required err=ff hold=0", error_count, cpu_hold);
    end
  endtask

  task automatic test_collision;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 12'h011;
    dec_we = 1'b1; dec_address = 32'h10; dec_data = 8'h11;
    #1;
    checks++;
    if (mem_we !== 1'b1 || mem_address !== 12'h010 || dec_write_done !== 1'b1) begin
      fails++;
      $display("FAIL collision_grant: we=%b addr=%h done=%b required we=1 addr=010 done=1", mem_we, mem_address, dec_write_done);
    end
    tick;
    dec_we = 1'b0;
    checks++;
    if (cpu_ack !== 1'b0 || cpu_hold !== 1'b1 || error_count !== 8'h0) begin
      fails++;
      $display("FAIL collision_state: ack=%b hold=%b err=%h required ack=0 hold=1 err=00", cpu_ack, cpu_hold, error_count);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (cpu_ack !== 1'b0) begin
        fails++;
        $display("FAIL load_no_ack cycle=%0d: ack=%b required 0", i, cpu_ack);
      end
    end
    cpu_req = 1'b0;
    dec_write(32'h100, 8'h22, 1'b1);
    eof(32'h88, 1'b0, 32'h88);
  endtask

  task automatic test_protect;
    cpu_access(1'b1, 12'h010, 8'hAA, 8'h00);
`ifdef IHEX_ARB_WRITE_PROTECT_EN
    cpu_access(1'b0, 12'h010, 8'h00, 8'h11);
`else
    cpu_access(1'b0, 12'h010, 8'h00, 8'hAA);
`endif
    cpu_access(1'b1, 12'h100, 8'hBB, 8'h00);
    cpu_access(1'b0, 12'h100, 8'h00, 8'hBB);
  endtask

  task automatic test_reset_mid;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 12'h012;
    #1;
    reset = 1'b1;
    tick;
    reset = 1'b0; cpu_req = 1'b0;
    checks++;
    if (cpu_ack !== 1'b0 || cpu_hold !== 1'b1 || boot_address !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid: ack=%b hold=%b boot=%h required ack=0 hold=1 boot=0", cpu_ack, cpu_hold, boot_address);
    end
    tick;
    checks++;
    if (cpu_ack !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_late: ack=%b required 0", cpu_ack);
    end
  endtask

  task automatic test_eof_with_error;
    dec_write(32'h30, 8'h05, 1'b1);
    line_error = 1'b1;
    eof(32'h90, 1'b1, 32'h0);
    line_error = 1'b0;
    checks++;
    if (error_count !== 8'd1) begin
      fails++;
      $display("FAIL eof_err_count: err=%0d required 1", error_count);
    end
  endtask

  initial begin
    reset = 1'b1; dec_we = 1'b0; end_of_file = 1'b0; line_error = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; dec_data = 8'h0; cpu_wdata = 8'h0;
    dec_address = 32'h0; start_address = 32'h0; cpu_address = 12'h0;
    test_reset;
    test_load;
    test_cpu;
    test_out_of_range;
    test_recover_saturate;
    test_collision;
    test_protect;
    test_reset_mid;
    test_eof_with_error;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
